// File: rtl/bsg_skid_fifo_pkg.sv
// Shared definitions for the two-entry skid FIFO.
// The state encoding doubles as the occupancy count.
package bsg_skid_fifo_pkg;

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1,
        FULL  = 2'd2
    } state_e;

endpackage

// File: rtl/bsg_dff_reset_en.sv
// Register with load enable and synchronous active-low clear to zero.
module bsg_dff_reset_en #(
    parameter int width_p = 16
) (
    input  logic               clk_i,
    input  logic               reset_n_i,
    input  logic               en_i,
    input  logic [width_p-1:0] data_i,
    output logic [width_p-1:0] data_o
);

    logic [width_p-1:0] data_q;

    always_ff @(posedge clk_i) begin
        if (!reset_n_i) begin
            data_q <= '0;
        end else if (en_i) begin
            data_q <= data_i;
        end
    end

    assign data_o = data_q;

endmodule

// File: rtl/bsg_skid_fifo.sv
// Two-entry in-order FIFO; every output comes straight from a register.
// Handshake: a word moves in when v_i & ready_o, and out when yumi_i & v_o.
module bsg_skid_fifo
    import bsg_skid_fifo_pkg::*;
#(
    parameter int width_p = 16
) (
    input  logic               clk_i,
    input  logic               reset_n_i,
    input  logic               v_i,
    input  logic [width_p-1:0] data_i,
    output logic               ready_o,
    output logic               v_o,
    output logic [width_p-1:0] data_o,
    input  logic               yumi_i,
    output logic [1:0]         count_o,
    output logic               err_o
);

    state_e             state_q, state_d;
    logic               err_q, err_d;
    logic               in_reset_q;
    logic               enq, deq;
    logic               head_en, tail_en, head_from_tail;
    logic [width_p-1:0] head_q, tail_q, head_d;

    // ready_o is held low for the cycle following a sampled reset.
    assign ready_o = ~in_reset_q & (state_q != FULL);
    assign v_o     = (state_q != EMPTY);
    assign count_o = 2'(state_q);
    assign err_o   = err_q;
    assign data_o  = head_q;

    assign enq = v_i & ready_o;
    assign deq = yumi_i & v_o;

    always_comb begin
        state_d        = state_q;
        head_en        = 1'b0;
        tail_en        = 1'b0;
        head_from_tail = 1'b0;
        err_d          = err_q | (v_i & ~ready_o) | (yumi_i & ~v_o);
        case (state_q)
            EMPTY: begin
                if (enq) begin
                    head_en = 1'b1;
                    state_d = ONE;
                end
            end
            ONE: begin
                if (enq && deq) begin
                    head_en = 1'b1;
                end else if (enq) begin
                    tail_en = 1'b1;
                    state_d = FULL;
                end else if (deq) begin
                    state_d = EMPTY;
                end
            end
            FULL: begin
                if (deq) begin
                    head_en        = 1'b1;
                    head_from_tail = 1'b1;
                    state_d        = ONE;
                end
            end
            default: state_d = EMPTY;
        endcase
    end

    assign head_d = head_from_tail ? tail_q : data_i;

    always_ff @(posedge clk_i) begin
        if (!reset_n_i) begin
            state_q    <= EMPTY;
            err_q      <= 1'b0;
            in_reset_q <= 1'b1;
        end else begin
            state_q    <= state_d;
            err_q      <= err_d;
            in_reset_q <= 1'b0;
        end
    end

    bsg_dff_reset_en #(.width_p(width_p)) head_reg (
        .clk_i     (clk_i),
        .reset_n_i (reset_n_i),
        .en_i      (head_en),
        .data_i    (head_d),
        .data_o    (head_q)
    );

    bsg_dff_reset_en #(.width_p(width_p)) tail_reg (
        .clk_i     (clk_i),
        .reset_n_i (reset_n_i),
        .en_i      (tail_en),
        .data_i    (data_i),
        .data_o    (tail_q)
    );

endmodule

// File: tb/tb_bsg_skid_fifo.sv
// Self-checking bench for bsg_skid_fifo: queue-based reference model,
// per-cycle compare process, and directed plus random stimulus.
module tb_bsg_skid_fifo;

    localparam int W = 16;

    logic         clk = 1'b0;
    logic         reset_n;
    logic         v_i;
    logic [W-1:0] data_i;
    logic         ready_o;
    logic         v_o;
    logic [W-1:0] data_o;
    logic         yumi_i;
    logic [1:0]   count_o;
    logic         err_o;

    always #5 clk = ~clk;

    bsg_skid_fifo #(.width_p(W)) dut (
        .clk_i     (clk),
        .reset_n_i (reset_n),
        .v_i       (v_i),
        .data_i    (data_i),
        .ready_o   (ready_o),
        .v_o       (v_o),
        .data_o    (data_o),
        .yumi_i    (yumi_i),
        .count_o   (count_o),
        .err_o     (err_o)
    );

    int n_pass  = 0;
    int n_total = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    // Reference model: contents as a plain queue, head at index 0.
    logic [W-1:0] exp_q[$];
    bit m_err      = 1'b0;
    bit m_in_reset = 1'b0;
    bit m_zero     = 1'b0;
    bit m_known    = 1'b0;
    bit m_rdy, m_vld;

    always @(posedge clk) begin
        if (!reset_n) begin
            exp_q.delete();
            m_err      = 1'b0;
            m_in_reset = 1'b1;
            m_zero     = 1'b1;
        end else begin
            m_rdy = !m_in_reset && (exp_q.size() < 2);
            m_vld = exp_q.size() > 0;
            if (v_i && !m_rdy) m_err = 1'b1;
            if (yumi_i && !m_vld) m_err = 1'b1;
            if (yumi_i && m_vld) void'(exp_q.pop_front());
            if (v_i && m_rdy) begin
                exp_q.push_back(data_i);
                m_zero = 1'b0;
            end
            m_in_reset = 1'b0;
        end
        m_known = 1'b1;
    end

    always @(negedge clk) begin
        if (m_known) begin
            check("v_o", 32'(v_o), 32'(exp_q.size() > 0));
            check("ready_o", 32'(ready_o), 32'(!m_in_reset && exp_q.size() < 2));
            check("count_o", 32'(count_o), 32'(exp_q.size()));
            check("err_o", 32'(err_o), 32'(m_err));
            if (exp_q.size() > 0) check("data_o", 32'(data_o), 32'(exp_q[0]));
            else if (m_zero) check("data_o_zero", 32'(data_o), 32'd0);
        end
    end

    // Words actually handed downstream by the DUT.
    logic [W-1:0] out_log[$];
    always @(posedge clk) begin
        if (reset_n && yumi_i && v_o) out_log.push_back(data_o);
    end

    task automatic drive(input logic v, input logic [W-1:0] d, input logic y, input logic rn);
        v_i     = v;
        data_i  = d;
        yumi_i  = y;
        reset_n = rn;
        @(negedge clk);
        #1;
    endtask

    int  errs;
    bit  cnt_ok;
    logic v_r, y_r, rn_r;

    initial begin
        reset_n = 1'b0;
        v_i     = 1'b0;
        data_i  = '0;
        yumi_i  = 1'b0;

        // Reset held for three cycles with garbage on the input.
        repeat (3) begin
            drive(1'b1, 16'hFFFF, 1'b0, 1'b0);
            check("rst_v_o", 32'(v_o), 32'd0);
            check("rst_ready_o", 32'(ready_o), 32'd0);
            check("rst_count_o", 32'(count_o), 32'd0);
            check("rst_data_o", 32'(data_o), 32'd0);
        end
        drive(1'b0, '0, 1'b0, 1'b1);
        check("rel_ready_o", 32'(ready_o), 32'd1);

        // Single transfer, held until consumed.
        drive(1'b1, 16'hA5A5, 1'b0, 1'b1);
        repeat (3) begin
            check("single_data", 32'(data_o), 32'hA5A5);
            check("single_count", 32'(count_o), 32'd1);
            drive(1'b0, '0, 1'b0, 1'b1);
        end
        drive(1'b0, '0, 1'b1, 1'b1);
        check("single_drained", 32'(count_o), 32'd0);

        // Fill then drain.
        out_log.delete();
        drive(1'b1, 16'h0001, 1'b0, 1'b1);
        drive(1'b1, 16'h0002, 1'b0, 1'b1);
        check("fill_count", 32'(count_o), 32'd2);
        check("fill_ready", 32'(ready_o), 32'd0);
        drive(1'b0, '0, 1'b1, 1'b1);
        drive(1'b0, '0, 1'b1, 1'b1);
        check("drain_count", 32'(count_o), 32'd0);
        check("drain_ready", 32'(ready_o), 32'd1);
        check("drain_n", 32'(out_log.size()), 32'd2);
        if (out_log.size() == 2) begin
            check("drain_first", 32'(out_log[0]), 32'h0001);
            check("drain_second", 32'(out_log[1]), 32'h0002);
        end

        // Streaming 1..100 at one word per cycle.
        out_log.delete();
        cnt_ok = 1'b1;
        drive(1'b1, 16'd1, 1'b0, 1'b1);
        for (int i = 2; i <= 100; i++) begin
            drive(1'b1, W'(i), 1'b1, 1'b1);
            if (count_o != 2'd1) cnt_ok = 1'b0;
        end
        drive(1'b0, '0, 1'b1, 1'b1);
        check("stream_count_const", 32'(cnt_ok), 32'd1);
        check("stream_n", 32'(out_log.size()), 32'd100);
        errs = 0;
        for (int i = 0; i < out_log.size(); i++)
            if (out_log[i] != W'(i + 1)) errs++;
        check("stream_order", 32'(errs), 32'd0);

        // Random legal traffic.
        repeat (300) begin
            v_r = ready_o && ($urandom_range(0, 1) == 1);
            y_r = v_o && ($urandom_range(0, 2) != 0);
            drive(v_r, W'($urandom_range(0, 16'hFFFF)), y_r, 1'b1);
        end
        repeat (3) drive(1'b0, '0, v_o, 1'b1);

        // Protocol violations: push while full, pop while empty.
        out_log.delete();
        drive(1'b1, 16'h0011, 1'b0, 1'b1);
        drive(1'b1, 16'h0022, 1'b0, 1'b1);
        drive(1'b1, 16'hDEAD, 1'b0, 1'b1);
        check("viol_full_count", 32'(count_o), 32'd2);
        check("viol_full_err", 32'(err_o), 32'd1);
        check("viol_full_head", 32'(data_o), 32'h0011);
        drive(1'b0, '0, 1'b1, 1'b1);
        drive(1'b0, '0, 1'b1, 1'b1);
        drive(1'b0, '0, 1'b1, 1'b1);
        check("viol_empty_count", 32'(count_o), 32'd0);
        errs = 0;
        foreach (out_log[i]) if (out_log[i] == 16'hDEAD) errs++;
        check("viol_no_dead", 32'(errs), 32'd0);
        check("viol_n", 32'(out_log.size()), 32'd2);
        repeat (5) drive(1'b0, '0, 1'b0, 1'b1);
        check("viol_err_sticky", 32'(err_o), 32'd1);

        // Reset in the middle of traffic discards contents.
        drive(1'b1, 16'h0033, 1'b0, 1'b1);
        drive(1'b1, 16'h0044, 1'b0, 1'b1);
        check("mid_full", 32'(count_o), 32'd2);
        drive(1'b1, 16'h0055, 1'b1, 1'b0);
        check("mid_count", 32'(count_o), 32'd0);
        check("mid_v_o", 32'(v_o), 32'd0);
        check("mid_err", 32'(err_o), 32'd0);
        drive(1'b0, '0, 1'b0, 1'b1);
        out_log.delete();
        for (int i = 0; i < 6; i++) drive(1'b1, W'(16'h0100 + i), v_o, 1'b1);
        repeat (3) drive(1'b0, '0, v_o, 1'b1);
        errs = 0;
        foreach (out_log[i]) if (out_log[i] == 16'h0033 || out_log[i] == 16'h0044) errs++;
        check("mid_no_stale", 32'(errs), 32'd0);
        check("mid_first_new", 32'(out_log.size() > 0 ? out_log[0] : '0), 32'h0100);

        // Random traffic with occasional violations and resets.
        repeat (400) begin
            rn_r = ($urandom_range(0, 99) >= 3);
            v_r  = ready_o ? ($urandom_range(0, 1) == 1) : ($urandom_range(0, 19) == 0);
            y_r  = v_o ? ($urandom_range(0, 2) != 0) : ($urandom_range(0, 19) == 0);
            drive(v_r, W'($urandom_range(0, 16'hFFFF)), y_r, rn_r);
        end
        drive(1'b0, '0, 1'b0, 1'b1);
        drive(1'b0, '0, 1'b0, 1'b1);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/bsg_skid_fifo.md
BSG_SKID_FIFO -- requirements
Module: bsg_skid_fifo

Interface
REQ-001 SHALL have parameter: width_p, 16, payload width in bits (>=1).
REQ-002 SHALL have port: clk_i  input  1  sole clock; all state updates on posedge.
REQ-003 SHALL have port: reset_n_i  input  1  reset, synchronous, active-low.
REQ-004 SHALL have port: v_i  input  1  upstream valid.
REQ-005 SHALL have port: data_i  input  width_p  upstream payload.
REQ-006 SHALL have port: ready_o  output  1  space available; upstream may assert v_i only when high.
REQ-007 SHALL have port: v_o  output  1  head entry valid.
REQ-008 SHALL have port: data_o  output  width_p  head entry payload.
REQ-009 SHALL have port: yumi_i  input  1  downstream consumes head this cycle; legal only when v_o high.
REQ-010 SHALL have port: count_o  output  2  occupancy, 0..2.
REQ-011 SHALL have port: err_o  output  1  sticky protocol-violation flag.

Function
REQ-012 SHALL implement a 2-entry in-order FIFO with states EMPTY (count 0), ONE (count 1) and FULL (count 2).
REQ-013 SHALL define enq = v_i & ready_o and deq = yumi_i & v_o.
REQ-014 SHALL drive ready_o = (state != FULL), v_o = (state != EMPTY) and count_o from state registers only, with no combinational path from any input to any output.
REQ-015 SHALL drive data_o directly from the head storage register.
REQ-016 SHALL give 1-cycle latency: data enqueued at edge N appears on data_o with v_o=1 in the cycle after edge N.
REQ-017 SHALL make these transitions: EMPTY+enq->ONE; ONE+enq only->FULL; ONE+deq only->EMPTY; ONE+enq+deq->ONE with head replaced by data_i; FULL+deq->ONE with second entry promoted to head; otherwise hold.
REQ-018 SHALL sustain one transfer per cycle in steady state when yumi_i is held high.
REQ-019 SHALL ignore v_i while ready_o=0, with no storage or state change, and set err_o.
REQ-020 SHALL ignore yumi_i while v_o=0, with no state change, and set err_o.
REQ-021 SHALL hold err_o high once set until reset.
REQ-022 SHALL preserve FIFO order with no loss or duplication under any legal interleaving.
REQ-023 SHALL hold data_o stable while v_o=1 and deq=0.

Reset
REQ-024 SHALL, in any cycle sampled with reset_n_i=0, force next state EMPTY, storage 0 and err_o 0, so that v_o=0, ready_o=0, count_o=0, data_o=0 and err_o=0 while in reset.
REQ-025 SHALL assert ready_o=1 in the first cycle after reset_n_i is sampled high.
REQ-026 SHALL discard all contents on reset asserted mid-operation, with reset taking priority over simultaneous enq/deq.

Structure
REQ-027 SHALL place the state encoding typedef (EMPTY=2'd0, ONE=2'd1, FULL=2'd2) in shared package bsg_skid_fifo_pkg.
REQ-028 SHALL build each storage entry from one sub-module, bsg_dff_reset_en (width_p, synchronous active-low reset to 0, load enable).
REQ-029 SHALL reuse bsg_skid_fifo_pkg encoding values in the count_o output.

Verification
REQ-030 SHALL cover reset: hold reset_n_i=0 for 3 cycles with v_i=1 and data_i=16'hFFFF -> v_o=0, ready_o=0, count_o=0, data_o=0; after release, ready_o=1.
REQ-031 SHALL cover single transfer: enq 16'hA5A5 at edge N with yumi_i=0 -> from cycle N+1, v_o=1, data_o=16'hA5A5, count_o=1, held until yumi_i.
REQ-032 SHALL cover fill/drain: enq 16'h0001 then 16'h0002 with yumi_i=0 -> count_o=2, ready_o=0; then yumi_i=1 for two cycles -> outputs 0001 then 0002, final count_o=0, ready_o=1.
REQ-033 SHALL cover streaming: v_i=1 and yumi_i=1 continuously with data 1..100 -> 100 outputs in order, count_o constant at 1 after first fill, throughput 1/cycle.
REQ-034 SHALL cover violations: v_i=1 while FULL with data_i=16'hDEAD, and yumi_i=1 while EMPTY -> 16'hDEAD never appears on data_o, count_o unchanged, err_o=1 until next reset.
REQ-035 SHALL cover mid-operation reset: count_o=2, then reset_n_i=0 for 1 cycle with enq/deq active -> count_o=0, v_o=0, err_o=0, prior data never emitted.
